// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes an XLEN-wide immediate, registers it behind a
// valid/ready handshake with a two-entry (main + skid) buffer, counts illegal formats.
// Build option: define IMM_GEN_PIPE_ZIMM_EN to enable fmt=6 (CSR zimm); otherwise fmt=6 is illegal.
module imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 5,
   parameter int ERRCNT_W = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_inst,
   input  logic [2:0]          in_fmt,
   input  logic                in_sext,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_imm,
   output logic [TAG_W-1:0]    out_tag,
   output logic                out_err,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam logic [2:0] FMT_I     = 3'd0;
   localparam logic [2:0] FMT_S     = 3'd1;
   localparam logic [2:0] FMT_B     = 3'd2;
   localparam logic [2:0] FMT_U     = 3'd3;
   localparam logic [2:0] FMT_J     = 3'd4;
   localparam logic [2:0] FMT_SHAMT = 3'd5;
   localparam logic [2:0] FMT_Z     = 3'd6;

   logic                ext_bit;
   logic [63:0]         imm_full;
   logic [XLEN-1:0]     new_imm;
   logic                new_err;
   logic                unused_bits;

   logic                in_xfer;
   logic                out_xfer;

   logic                main_vld_q, main_vld_d;
   logic [XLEN-1:0]     main_imm_q, main_imm_d;
   logic [TAG_W-1:0]    main_tag_q, main_tag_d;
   logic                main_err_q, main_err_d;
   logic                skid_vld_q, skid_vld_d;
   logic [XLEN-1:0]     skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0]    skid_tag_q, skid_tag_d;
   logic                skid_err_q, skid_err_d;
   logic                in_ready_q, in_ready_d;
   logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

   // Immediate is built 64 bits wide and truncated, so XLEN=32 simply drops the upper fill.
   always_comb begin
      ext_bit  = in_sext & in_inst[31];
      imm_full = '0;
      new_err  = 1'b0;
      case (in_fmt)
         FMT_I: imm_full = {{52{ext_bit}}, in_inst[31:20]};
         FMT_S: imm_full = {{52{ext_bit}}, in_inst[31:25], in_inst[11:7]};
         FMT_B: imm_full = {{51{ext_bit}}, in_inst[31], in_inst[7], in_inst[30:25],
                            in_inst[11:8], 1'b0};
         FMT_U: imm_full = {{32{ext_bit}}, in_inst[31:12], 12'b0};
         FMT_J: imm_full = {{43{ext_bit}}, in_inst[31], in_inst[19:12], in_inst[20],
                            in_inst[30:21], 1'b0};
         FMT_SHAMT: begin
            if (XLEN == 32) begin
               imm_full = {59'b0, in_inst[24:20]};
               new_err  = in_inst[25];
            end else begin
               imm_full = {58'b0, in_inst[25:20]};
            end
         end
`ifdef IMM_GEN_PIPE_ZIMM_EN
         FMT_Z: imm_full = {59'b0, in_inst[19:15]};
`else
         FMT_Z: new_err = 1'b1;
`endif
         default: new_err = 1'b1;
      endcase
      new_imm = imm_full[XLEN-1:0];
   end

   assign unused_bits = ^{in_inst[6:0], imm_full};

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = main_vld_q & out_ready;

   // Skid only ever fills while main is held, and in_ready is low whenever skid is full,
   // so a skid->main move never coincides with an input transfer.
   always_comb begin
      main_vld_d = main_vld_q;
      main_imm_d = main_imm_q;
      main_tag_d = main_tag_q;
      main_err_d = main_err_q;
      skid_vld_d = skid_vld_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_err_d = skid_err_q;
      err_cnt_d  = err_cnt_q;

      if (out_xfer && skid_vld_q) begin
         main_imm_d = skid_imm_q;
         main_tag_d = skid_tag_q;
         main_err_d = skid_err_q;
         skid_vld_d = 1'b0;
      end else if (in_xfer) begin
         if (!main_vld_q || out_xfer) begin
            main_vld_d = 1'b1;
            main_imm_d = new_imm;
            main_tag_d = in_tag;
            main_err_d = new_err;
         end else begin
            skid_vld_d = 1'b1;
            skid_imm_d = new_imm;
            skid_tag_d = in_tag;
            skid_err_d = new_err;
         end
      end else if (out_xfer) begin
         main_vld_d = 1'b0;
      end

      if (in_xfer && new_err && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end

      in_ready_d = ~skid_vld_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_vld_q <= 1'b0;
         main_imm_q <= '0;
         main_tag_q <= '0;
         main_err_q <= 1'b0;
         skid_vld_q <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
         skid_err_q <= 1'b0;
         in_ready_q <= 1'b1;
         err_cnt_q  <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         main_imm_q <= main_imm_d;
         main_tag_q <= main_tag_d;
         main_err_q <= main_err_d;
         skid_vld_q <= skid_vld_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
         skid_err_q <= skid_err_d;
         in_ready_q <= in_ready_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_vld_q;
   assign out_imm   = main_imm_q;
   assign out_tag   = main_tag_q;
   assign out_err   = main_err_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32, XLEN=64 and ERRCNT_W=2 instances share stimulus.
module tb_imm_gen_pipe;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [2:0]  in_fmt;
   logic        in_sext;
   logic [4:0]  in_tag;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_out_err;
   logic [31:0] a_out_imm;
   logic [4:0]  a_out_tag;
   logic [15:0] a_err_count;

   logic        b_in_ready, b_out_valid, b_out_err;
   logic [63:0] b_out_imm;
   logic [4:0]  b_out_tag;
   logic [15:0] b_err_count;

   logic        c_in_ready, c_out_valid, c_out_err;
   logic [31:0] c_out_imm;
   logic [4:0]  c_out_tag;
   logic [1:0]  c_err_count;

   int errors = 0;
   int checks = 0;
   int exp_cnt_a = 0;
   int exp_cnt_b = 0;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ERRCNT_W(16)) u_a (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_inst(in_inst), .in_fmt(in_fmt), .in_sext(in_sext), .in_tag(in_tag),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
      .out_tag(a_out_tag), .out_err(a_out_err), .err_count(a_err_count));

   imm_gen_pipe #(.XLEN(64), .TAG_W(5), .ERRCNT_W(16)) u_b (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_inst(in_inst), .in_fmt(in_fmt), .in_sext(in_sext), .in_tag(in_tag),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
      .out_tag(b_out_tag), .out_err(b_out_err), .err_count(b_err_count));

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ERRCNT_W(2)) u_c (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_inst(in_inst), .in_fmt(in_fmt), .in_sext(in_sext), .in_tag(in_tag),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_imm(c_out_imm),
      .out_tag(c_out_tag), .out_err(c_out_err), .err_count(c_err_count));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one instruction for a single edge, then observe #1 after that edge.
   task automatic drive(input logic [2:0] fmt, input logic [31:0] inst,
                        input logic sext, input logic [4:0] tag);
      in_valid = 1'b1;
      in_fmt   = fmt;
      in_inst  = inst;
      in_sext  = sext;
      in_tag   = tag;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_err_count !== 16'd0 ||
          a_out_imm !== 32'd0 || a_out_tag !== 5'd0 || a_out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b ready=%b cnt=%0d imm=%h tag=%0d err=%b, want 0 1 0 0 0 0",
                  a_out_valid, a_in_ready, a_err_count, a_out_imm, a_out_tag, a_out_err);
      end
   endtask

   task automatic test_i_fmt;
      drive(3'd0, 32'hFFF00093, 1'b1, 5'd4);
      checks++;
      if (a_out_valid !== 1'b1 || a_out_imm !== 32'hFFFFFFFF || a_out_tag !== 5'd4 || a_out_err !== 1'b0) begin
         errors++;
         $display("FAIL i_sext32: got valid=%b imm=%h tag=%0d err=%b, want 1 ffffffff 4 0",
                  a_out_valid, a_out_imm, a_out_tag, a_out_err);
      end
      checks++;
      if (b_out_imm !== 64'hFFFFFFFFFFFFFFFF) begin
         errors++;
         $display("FAIL i_sext64: got %h want ffffffffffffffff", b_out_imm);
      end
      drive(3'd0, 32'hFFF00093, 1'b0, 5'd5);
      checks++;
      if (a_out_valid !== 1'b1 || a_out_imm !== 32'h00000FFF || a_out_tag !== 5'd5) begin
         errors++;
         $display("FAIL i_zext32: got valid=%b imm=%h tag=%0d, want 1 00000fff 5",
                  a_out_valid, a_out_imm, a_out_tag);
      end
   endtask

   task automatic test_s_b_j_fmt;
      drive(3'd1, 32'hFE112E23, 1'b1, 5'd6);
      checks++;
      if (a_out_imm !== 32'hFFFFFFFC || a_out_err !== 1'b0) begin
         errors++;
         $display("FAIL s_fmt: got imm=%h err=%b want fffffffc 0", a_out_imm, a_out_err);
      end
      drive(3'd2, 32'hFE000EE3, 1'b1, 5'd7);
      checks++;
      if (a_out_imm !== 32'hFFFFFFFC) begin
         errors++;
         $display("FAIL b_fmt: got %h want fffffffc", a_out_imm);
      end
      drive(3'd4, 32'h800000EF, 1'b1, 5'd8);
      checks++;
      if (a_out_imm !== 32'hFFF00000 || b_out_imm !== 64'hFFFFFFFFFFF00000) begin
         errors++;
         $display("FAIL j_fmt: got %h / %h want fff00000 / fffffffffff00000", a_out_imm, b_out_imm);
      end
   endtask

   task automatic test_u_fmt;
      drive(3'd3, 32'h800000B7, 1'b1, 5'd9);
      checks++;
      if (b_out_imm !== 64'hFFFFFFFF80000000 || a_out_imm !== 32'h80000000) begin
         errors++;
         $display("FAIL u_neg: got %h / %h want ffffffff80000000 / 80000000", b_out_imm, a_out_imm);
      end
      drive(3'd3, 32'h123450B7, 1'b1, 5'd10);
      checks++;
      if (b_out_imm !== 64'h0000000012345000) begin
         errors++;
         $display("FAIL u_pos: got %h want 0000000012345000", b_out_imm);
      end
   endtask

   task automatic test_shamt;
      drive(3'd5, 32'h02009093, 1'b1, 5'd11);
      exp_cnt_a++;
      checks++;
      if (a_out_imm !== 32'd0 || a_out_err !== 1'b1 || a_err_count !== 16'(exp_cnt_a)) begin
         errors++;
         $display("FAIL shamt32: got imm=%h err=%b cnt=%0d want 0 1 %0d",
                  a_out_imm, a_out_err, a_err_count, exp_cnt_a);
      end
      checks++;
      if (b_out_imm !== 64'h20 || b_out_err !== 1'b0 || b_err_count !== 16'(exp_cnt_b)) begin
         errors++;
         $display("FAIL shamt64: got imm=%h err=%b cnt=%0d want 20 0 %0d",
                  b_out_imm, b_out_err, b_err_count, exp_cnt_b);
      end
      drive(3'd5, 32'h01F09093, 1'b1, 5'd12);
      checks++;
      if (a_out_imm !== 32'h1F || a_out_err !== 1'b0 || a_err_count !== 16'(exp_cnt_a)) begin
         errors++;
         $display("FAIL shamt32_max: got imm=%h err=%b cnt=%0d want 1f 0 %0d",
                  a_out_imm, a_out_err, a_err_count, exp_cnt_a);
      end
   endtask

   task automatic test_illegal;
      drive(3'd6, 32'hFFFF8073, 1'b1, 5'd13);
`ifdef IMM_GEN_PIPE_ZIMM_EN
      checks++;
      if (a_out_imm !== 32'h1F || a_out_err !== 1'b0 || a_err_count !== 16'(exp_cnt_a)) begin
         errors++;
         $display("FAIL zimm: got imm=%h err=%b cnt=%0d want 1f 0 %0d",
                  a_out_imm, a_out_err, a_err_count, exp_cnt_a);
      end
`else
      exp_cnt_a++;
      exp_cnt_b++;
      checks++;
      if (a_out_imm !== 32'h0 || a_out_err !== 1'b1 || a_err_count !== 16'(exp_cnt_a)) begin
         errors++;
         $display("FAIL zimm_off: got imm=%h err=%b cnt=%0d want 0 1 %0d",
                  a_out_imm, a_out_err, a_err_count, exp_cnt_a);
      end
`endif
      drive(3'd7, 32'hFFFFFFFF, 1'b1, 5'd14);
      exp_cnt_a++;
      exp_cnt_b++;
      checks++;
      if (b_out_imm !== 64'h0 || b_out_err !== 1'b1 || b_err_count !== 16'(exp_cnt_b) ||
          a_err_count !== 16'(exp_cnt_a)) begin
         errors++;
         $display("FAIL fmt7: got imm=%h err=%b cnt64=%0d cnt32=%0d want 0 1 %0d %0d",
                  b_out_imm, b_out_err, b_err_count, a_err_count, exp_cnt_b, exp_cnt_a);
      end
      @(posedge clock);
      #1;
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: got valid=%b want 0", a_out_valid);
      end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      in_valid = 1'b1; in_fmt = 3'd0; in_inst = 32'h00100093; in_sext = 1'b1; in_tag = 5'd1;
      @(posedge clock); #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_tag !== 5'd1 || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first: got valid=%b tag=%0d ready=%b want 1 1 1", a_out_valid, a_out_tag, a_in_ready);
      end
      in_tag = 5'd2;
      @(posedge clock); #1;
      checks++;
      if (a_in_ready !== 1'b0 || a_out_tag !== 5'd1) begin
         errors++;
         $display("FAIL bp_full: got ready=%b tag=%0d want 0 1", a_in_ready, a_out_tag);
      end
      in_tag = 5'd3;
      @(posedge clock); #1;
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_tag !== 5'd1 || a_out_imm !== 32'h1) begin
         errors++;
         $display("FAIL bp_hold: got ready=%b valid=%b tag=%0d imm=%h want 0 1 1 1",
                  a_in_ready, a_out_valid, a_out_tag, a_out_imm);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_tag !== 5'd2 || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_tag2: got valid=%b tag=%0d ready=%b want 1 2 1", a_out_valid, a_out_tag, a_in_ready);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_tag !== 5'd3) begin
         errors++;
         $display("FAIL bp_tag3: got valid=%b tag=%0d want 1 3", a_out_valid, a_out_tag);
      end
      @(posedge clock); #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_empty: got valid=%b ready=%b want 0 1", a_out_valid, a_in_ready);
      end
   endtask

   task automatic test_async_reset;
      out_ready = 1'b0;
      in_valid = 1'b1; in_fmt = 3'd7; in_inst = 32'h0; in_sext = 1'b0; in_tag = 5'd21;
      @(posedge clock); #1;
      in_tag = 5'd22;
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_prefill: got ready=%b valid=%b want 0 1", a_in_ready, a_out_valid);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_err_count !== 16'd0 || a_out_tag !== 5'd0) begin
         errors++;
         $display("FAIL rst_async: got valid=%b ready=%b cnt=%0d tag=%0d want 0 1 0 0",
                  a_out_valid, a_in_ready, a_err_count, a_out_tag);
      end
      #2;
      reset = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_stays_empty: got valid=%b want 0", a_out_valid);
      end
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 5; i++) begin
         drive(3'd7, 32'h0, 1'b0, 5'(i));
         if (i == 2) begin
            checks++;
            if (c_err_count !== 2'd3) begin
               errors++;
               $display("FAIL sat_reach: got %0d want 3", c_err_count);
            end
         end
      end
      checks++;
      if (c_err_count !== 2'd3 || a_err_count !== 16'd5) begin
         errors++;
         $display("FAIL sat_hold: got cnt2=%0d cnt16=%0d want 3 5", c_err_count, a_err_count);
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_inst = 32'h0;
      in_fmt = 3'd0;
      in_sext = 1'b0;
      in_tag = 5'd0;
      out_ready = 1'b1;
      #3;
      test_reset;
      #13;
      reset = 1'b0;
      test_i_fmt;
      test_s_b_j_fmt;
      test_u_fmt;
      test_shamt;
      test_illegal;
      test_back_to_back;
      test_async_reset;
      test_saturation;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
